// File: rtl/psa_pkg.sv
// Shared definitions for the partitioned (sub-word) serial adder.
// Holds the controller state encoding, the nibble width and the
// saturation constants used when overflowing nibbles are clamped.
package psa_pkg;

  localparam int NIB_W = 4;

  localparam logic [NIB_W-1:0] SAT_POS = 4'h7;
  localparam logic [NIB_W-1:0] SAT_NEG = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_4bit.sv
// Purpose: 4-bit two's-complement adder/subtractor with signed overflow flag.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: a, b operands; sub selects a-b; s result; cout carry out;
//        Ovfl set when the signed result does not fit in 4 bits.
module addsub_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] s,
  output logic       cout,
  output logic       Ovfl
);

  logic [3:0] b_eff;

  assign b_eff       = b ^ {4{sub}};
  assign {cout, s}   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, sub};
  // Signed overflow: operands agree in sign but the result does not.
  assign Ovfl        = (a[3] == b_eff[3]) && (s[3] != a[3]);

endmodule

// File: rtl/psa_serial_ctrl.sv
// Purpose: serial partitioned adder, one signed nibble per cycle (LSB first)
//          through a single shared 4-bit adder; no carry between nibbles.
// Latency: out_valid rises NIBBLES cycles after the accept edge; one op per NIBBLES+2 cycles.
// Backpressure: in_ready low while busy; result held in DONE until out_ready.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with sum, err_mask (per-nibble overflow), error (OR of err_mask).
// Option: define PSA_SAT_EN to saturate overflowing nibbles to 4'h7/4'h8
//         instead of wrapping; the err_mask bit is set in both builds.
module psa_serial_ctrl
  import psa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*NIBBLES-1:0]     a,
  input  logic [4*NIBBLES-1:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*NIBBLES-1:0]     sum,
  output logic [NIBBLES-1:0]       err_mask,
  output logic                     error
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [CNT_W-1:0] cnt;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] add_s;
  logic [NIB_W-1:0] nib_res;
  logic             add_ovfl;
  logic             add_cout_unused;

  // Operands come from the captured copies so later input changes are ignored.
  assign a_nib = a_q[NIB_W*int'(cnt) +: NIB_W];
  assign b_nib = b_q[NIB_W*int'(cnt) +: NIB_W];

  addsub_4bit u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .sub  (1'b0),
    .s    (add_s),
    .cout (add_cout_unused),
    .Ovfl (add_ovfl)
  );

`ifdef PSA_SAT_EN
  // Overflow only happens when both signs agree, so a's sign gives the direction.
  assign nib_res = add_ovfl ? (a_nib[NIB_W-1] ? SAT_NEG : SAT_POS) : add_s;
`else
  assign nib_res = add_s;
`endif

  assign error = |err_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      sum       <= '0;
      err_mask  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            sum      <= '0;
            err_mask <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          sum[NIB_W*int'(cnt) +: NIB_W] <= nib_res;
          err_mask[cnt]                 <= add_ovfl;
          if (cnt == CNT_LAST) begin
            // Park the counter in range rather than stepping past the last lane.
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psa_serial_ctrl.sv
// Self-checking bench for psa_serial_ctrl: table of operand/result vectors,
// random operands against a signed-integer model, and hand-written sequences
// for result hold, mid-operation reset and back-to-back throughput.
module tb_psa_serial_ctrl;

  localparam int NIBBLES = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic [3:0]  err_mask;
  logic        error;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s_wrap;
    logic [15:0] s_sat;
    logic [3:0]  mask;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  m;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  psa_serial_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .err_mask  (err_mask),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: signed integer add per nibble, then wrap or clamp.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] s, output logic [3:0] m);
    s = '0;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      int sx, sy, r;
      sx = int'($signed(x[4*i +: 4]));
      sy = int'($signed(y[4*i +: 4]));
      r  = sx + sy;
      m[i] = (r > 7) || (r < -8);
`ifdef PSA_SAT_EN
      if (r > 7) r = 7;
      else if (r < -8) r = -8;
`endif
      s[4*i +: 4] = 4'(r);
    end
  endfunction

  function automatic logic [15:0] pick(input vec_t v);
`ifdef PSA_SAT_EN
    return v.s_sat;
`else
    return v.s_wrap;
`endif
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: result seen with no expected entry queued", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"},   32'(sum),      32'(e.s));
      check({tag, "_mask"},  32'(err_mask), 32'(e.m));
      check({tag, "_error"}, 32'(error),    32'(|e.m));
    end
  endtask

  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                       input logic [15:0] es, input logic [3:0] em, input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(exp_t'{s: es, m: em});
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check({tag, "_latency"}, 32'(k), 32'(NIBBLES));
    check({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
    pop_check(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] es;
    logic [3:0]  em;
    int          k;
    int          seen;
    int          cyc;
    int          last_acc;
    int          idx;
    int          n_done;
    logic        acc;

    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 16'h2345, 4'b0000};
    vecs[1] = '{16'h7000, 16'h1000, 16'h8000, 16'h7000, 4'b1000};
    vecs[2] = '{16'h0008, 16'h000F, 16'h0007, 16'h0008, 4'b0001};
    vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFF0, 16'hFFF0, 4'b0000};
    vecs[4] = '{16'h7777, 16'h7777, 16'hEEEE, 16'h7777, 4'b1111};
    vecs[5] = '{16'h8888, 16'h8888, 16'h0000, 16'h8888, 4'b1111};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000};
    vecs[7] = '{16'h3C5A, 16'h4D69, 16'h79B3, 16'h7978, 4'b0011};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_mask",      32'(err_mask),  32'd0);
    check("rst_error",     32'(error),     32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, pick(vecs[i]), vecs[i].mask, $sformatf("vec%0d", i));

    // Random operands against the model
    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      model(ra, rb, es, em);
      do_op(ra, rb, es, em, $sformatf("rnd%0d", i));
    end

    // Result hold under backpressure with in_valid pulsing
    a = 16'h1234;
    b = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(exp_t'{s: 16'h2345, m: 4'b0000});
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check("hold_latency", 32'(k), 32'(NIBBLES));
    pop_check("hold_first");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      check($sformatf("hold%0d_ov", i),   32'(out_valid), 32'd1);
      check($sformatf("hold%0d_sum", i),  32'(sum),       32'h2345);
      check($sformatf("hold%0d_mask", i), 32'(err_mask),  32'd0);
      check($sformatf("hold%0d_rdy", i),  32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_ov",  32'(out_valid), 32'd0);
    check("hold_release_rdy", 32'(in_ready),  32'd1);
    seen = 0;
    repeat (6) begin tick(); if (out_valid || !in_ready) seen = 1; end
    check("hold_no_capture", 32'(seen), 32'd0);

    // Reset while in CALC with cnt == 2
    a = 16'h1234;
    b = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    tick();
    check("midrst_partial", 32'(sum), 32'h0045);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy",  32'(in_ready),  32'd1);
    check("midrst_ov",   32'(out_valid), 32'd0);
    check("midrst_sum",  32'(sum),       32'd0);
    check("midrst_mask", 32'(err_mask),  32'd0);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin tick(); if (out_valid) seen = 1; end
    check("midrst_no_result", 32'(seen), 32'd0);

    // Back-to-back with in_valid and out_ready held high
    idx      = 0;
    n_done   = 0;
    cyc      = 0;
    last_acc = -1;
    a        = vecs[0].a;
    b        = vecs[0].b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (n_done < 3 && cyc < 60) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        pop_check($sformatf("b2b%0d", n_done));
        n_done++;
      end
      @(posedge clk);
      if (acc) begin
        sb.push_back(exp_t'{s: pick(vecs[idx]), m: vecs[idx].mask});
        if (last_acc >= 0)
          check($sformatf("b2b_spacing%0d", idx), 32'(cyc - last_acc), 32'(NIBBLES + 2));
        last_acc = cyc;
        idx++;
      end
      #1;
      cyc++;
      if (acc) begin
        if (idx < 3) begin
          a = vecs[idx].a;
          b = vecs[idx].b;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_done_count", 32'(n_done), 32'd3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
